delivery_request_queue: RTL and testbench

Buffers message-delivery requests raised by core 0 and core 1 on channel rendezvous and feeds them, one at a time, to the message-delivery stage. It sits directly upstream of that stage: it arbitrates between the two cores, holds pending requests in a small FIFO, and drives the delivery stage's start/finished handshake. It also reports back to the sender which core, if any, received the message in-register.

---
 rtl/delivery_request_queue_pkg.sv | 31 +++
 rtl/delivery_request_queue_request_fifo.sv | 69 ++++++
 rtl/delivery_request_queue.sv | 245 ++++++++++++++++++++++++
 tb/tb_delivery_request_queue.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delivery_request_queue_pkg.sv
// ----------------------------------------------------------------------------
// delivery_request_queue_pkg
//   Shared definitions for the delivery request queue:
//     - default process-address and message widths (`ADDRESS_BITS, `DATA_BITS)
//     - JUMP_BITS: width of a jump destination PC
//     - bit offsets of the fields inside a queued entry
//     - FSM state encodings for the delivery handshake
//   Entry layout (MSB..LSB): {target_process, message, needs_jump, jump_dest}
// ----------------------------------------------------------------------------
`ifndef ADDRESS_BITS
`define ADDRESS_BITS 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 32
`endif

package delivery_request_queue_pkg;

  localparam int JUMP_BITS = 9;

  // Fixed-position fields at the bottom of an entry; message and target sit
  // above them and their offsets depend on the data width.
  localparam int JUMP_OFS       = 0;
  localparam int NEEDS_JUMP_OFS = JUMP_BITS;
  localparam int MSG_OFS        = JUMP_BITS + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

endpackage

// File: rtl/delivery_request_queue_request_fifo.sv
// ----------------------------------------------------------------------------
// delivery_request_queue_request_fifo
//   Synchronous FIFO with two push ports and one pop port. When both pushes
//   fire in the same cycle, data_a lands at the lower (earlier) slot.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     push_a / data_a     first push of the cycle
//     push_b / data_b     second push of the cycle (only with push_a)
//     pop                 discard head entry
//     head                current head entry (combinational read)
//     count               occupied entries
//   The caller guarantees no overflow/underflow.
// ----------------------------------------------------------------------------
module delivery_request_queue_request_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_a,
  input  logic [WIDTH-1:0]         data_a,
  input  logic                     push_b,
  input  logic [WIDTH-1:0]         data_b,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_plus1;

  // Depth is a power of two, so natural pointer overflow is the modulo wrap.
  assign wr_ptr_plus1 = wr_ptr_q + PTR_W'(1'b1);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_a) + PTR_W'(push_b);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage holds no control state, so it is left out of the reset.
  always_ff @(posedge clk) begin
    if (push_a) mem[wr_ptr_q] <= data_a;
    if (push_b) mem[wr_ptr_plus1] <= data_b;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/delivery_request_queue.sv
// ----------------------------------------------------------------------------
// delivery_request_queue
//   Collects message-delivery requests from core 0 and core 1, arbitrates
//   round-robin, queues them, and feeds them one at a time to the delivery
//   stage through a start/finished handshake. Reports back which core took
//   the message in-register via one-cycle notify pulses.
//   Ports:
//     clk, reset                    clock, asynchronous active-low reset
//     coreN*                        request valid/ready and fields (N = 0, 1)
//     deliveryStart/Finished        delivery-stage handshake
//     targetProcess..jumpDestination head entry presented to delivery stage
//     deliveredToCore0/1            delivery result, valid with Finished
//     core0Notify/core1Notify       one-cycle result pulses
//     queueCount                    occupied entries
//   Optional (DELIVERY_QUEUE_STATS_EN defined):
//     deliveredCount                pops, wrapping
//     stallCycles                   cycles with a valid-but-not-ready request,
//                                   saturating
// ----------------------------------------------------------------------------
`ifndef ADDRESS_BITS
`define ADDRESS_BITS 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 32
`endif

module delivery_request_queue
  import delivery_request_queue_pkg::*;
#(
  parameter int addrBits = `ADDRESS_BITS,
  parameter int dataBits = `DATA_BITS,
  parameter int depth    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     core0ReqValid,
  output logic                     core0ReqReady,
  input  logic [addrBits-1:0]      core0TargetProcess,
  input  logic [dataBits-1:0]      core0Message,
  input  logic                     core0NeedsJump,
  input  logic [8:0]               core0JumpDestination,
  input  logic                     core1ReqValid,
  output logic                     core1ReqReady,
  input  logic [addrBits-1:0]      core1TargetProcess,
  input  logic [dataBits-1:0]      core1Message,
  input  logic                     core1NeedsJump,
  input  logic [8:0]               core1JumpDestination,
  output logic                     deliveryStart,
  input  logic                     deliveryFinished,
  output logic [addrBits-1:0]      targetProcess,
  output logic [dataBits-1:0]      message,
  output logic                     needsJump,
  output logic [8:0]               jumpDestination,
  input  logic                     deliveredToCore0,
  input  logic                     deliveredToCore1,
  output logic                     core0Notify,
  output logic                     core1Notify,
  output logic [$clog2(depth):0]   queueCount
`ifdef DELIVERY_QUEUE_STATS_EN
  ,
  output logic [15:0]              deliveredCount,
  output logic [15:0]              stallCycles
`endif
);

  localparam int EW         = addrBits + dataBits + JUMP_BITS + 1;
  localparam int TARGET_OFS = MSG_OFS + dataBits;
  localparam int CNT_W      = $clog2(depth) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(depth);
  localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(depth - 1);

  logic [EW-1:0]    entry0, entry1, push_data_a, push_data_b, head;
  logic [CNT_W-1:0] fifo_count;
  logic             push_a, push_b, pop;
  logic             grant0, grant1, both_valid;

  logic                prio_q, prio_d;              // 0: core 0 has priority
  logic [1:0]          state_q, state_d;
  logic                start_q, start_d;
  logic                notify0_q, notify0_d;
  logic                notify1_q, notify1_d;
  logic [addrBits-1:0] target_q, target_d;
  logic [dataBits-1:0] message_q, message_d;
  logic                needs_jump_q, needs_jump_d;
  logic [8:0]          jump_dest_q, jump_dest_d;

  assign entry0 = {core0TargetProcess, core0Message, core0NeedsJump, core0JumpDestination};
  assign entry1 = {core1TargetProcess, core1Message, core1NeedsJump, core1JumpDestination};

  // Readies look only at registered occupancy, so a pop frees space for the
  // ready logic one cycle later.
  assign both_valid = core0ReqValid & core1ReqValid;

  always_comb begin
    core0ReqReady = 1'b0;
    core1ReqReady = 1'b0;
    if (fifo_count != DEPTH_C) begin
      if (fifo_count == DEPTH_M1 && both_valid) begin
        core0ReqReady = ~prio_q;
        core1ReqReady = prio_q;
      end else begin
        core0ReqReady = 1'b1;
        core1ReqReady = 1'b1;
      end
    end
  end

  assign grant0 = core0ReqValid & core0ReqReady;
  assign grant1 = core1ReqValid & core1ReqReady;

  // On a double grant the priority port's entry takes the earlier slot.
  always_comb begin
    push_a      = grant0 | grant1;
    push_b      = grant0 & grant1;
    push_data_b = prio_q ? entry0 : entry1;
    if (grant0 && grant1) begin
      push_data_a = prio_q ? entry1 : entry0;
    end else begin
      push_data_a = grant0 ? entry0 : entry1;
    end
    prio_d = prio_q ^ (both_valid & (grant0 | grant1));
  end

  delivery_request_queue_request_fifo #(
    .WIDTH (EW),
    .DEPTH (depth)
  ) u_request_fifo (
    .clk    (clk),
    .rst_n  (reset),
    .push_a (push_a),
    .data_a (push_data_a),
    .push_b (push_b),
    .data_b (push_data_b),
    .pop    (pop),
    .head   (head),
    .count  (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    notify0_d    = notify0_q;
    notify1_d    = notify1_q;
    target_d     = target_q;
    message_d    = message_q;
    needs_jump_d = needs_jump_q;
    jump_dest_d  = jump_dest_q;
    pop          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_count != '0) begin
          target_d     = head[TARGET_OFS +: addrBits];
          message_d    = head[MSG_OFS +: dataBits];
          needs_jump_d = head[NEEDS_JUMP_OFS];
          jump_dest_d  = head[JUMP_OFS +: JUMP_BITS];
          start_d      = 1'b1;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        if (deliveryFinished) begin
          notify0_d = deliveredToCore0;
          notify1_d = deliveredToCore1;
          start_d   = 1'b0;
          pop       = 1'b1;
          state_d   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        notify0_d = 1'b0;
        notify1_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        notify0_d = 1'b0;
        notify1_d = 1'b0;
        start_d   = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q       <= 1'b0;
      state_q      <= ST_IDLE;
      start_q      <= 1'b0;
      notify0_q    <= 1'b0;
      notify1_q    <= 1'b0;
      target_q     <= '0;
      message_q    <= '0;
      needs_jump_q <= 1'b0;
      jump_dest_q  <= '0;
    end else begin
      prio_q       <= prio_d;
      state_q      <= state_d;
      start_q      <= start_d;
      notify0_q    <= notify0_d;
      notify1_q    <= notify1_d;
      target_q     <= target_d;
      message_q    <= message_d;
      needs_jump_q <= needs_jump_d;
      jump_dest_q  <= jump_dest_d;
    end
  end

  assign deliveryStart   = start_q;
  assign core0Notify     = notify0_q;
  assign core1Notify     = notify1_q;
  assign targetProcess   = target_q;
  assign message         = message_q;
  assign needsJump       = needs_jump_q;
  assign jumpDestination = jump_dest_q;
  assign queueCount      = fifo_count;

`ifdef DELIVERY_QUEUE_STATS_EN
  logic [15:0] delivered_count_q, delivered_count_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic        stall;

  assign stall = (core0ReqValid & ~core0ReqReady) | (core1ReqValid & ~core1ReqReady);

  always_comb begin
    delivered_count_d = delivered_count_q + 16'(pop);
    stall_cycles_d    = stall_cycles_q;
    if (stall && stall_cycles_q != 16'hFFFF) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      delivered_count_q <= '0;
      stall_cycles_q    <= '0;
    end else begin
      delivered_count_q <= delivered_count_d;
      stall_cycles_q    <= stall_cycles_d;
    end
  end

  assign deliveredCount = delivered_count_q;
  assign stallCycles    = stall_cycles_q;
`endif

endmodule

// File: tb/tb_delivery_request_queue.sv
// ----------------------------------------------------------------------------
// tb_delivery_request_queue
//   Directed bench for delivery_request_queue (depth 4). Counter checks are
//   included when DELIVERY_QUEUE_STATS_EN is defined.
// ----------------------------------------------------------------------------
`ifndef ADDRESS_BITS
`define ADDRESS_BITS 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 32
`endif

module tb_delivery_request_queue;

  localparam int AW = `ADDRESS_BITS;
  localparam int DW = `DATA_BITS;

  logic          clk;
  logic          reset;
  logic          core0ReqValid, core0ReqReady;
  logic [AW-1:0] core0TargetProcess;
  logic [DW-1:0] core0Message;
  logic          core0NeedsJump;
  logic [8:0]    core0JumpDestination;
  logic          core1ReqValid, core1ReqReady;
  logic [AW-1:0] core1TargetProcess;
  logic [DW-1:0] core1Message;
  logic          core1NeedsJump;
  logic [8:0]    core1JumpDestination;
  logic          deliveryStart, deliveryFinished;
  logic [AW-1:0] targetProcess;
  logic [DW-1:0] message;
  logic          needsJump;
  logic [8:0]    jumpDestination;
  logic          deliveredToCore0, deliveredToCore1;
  logic          core0Notify, core1Notify;
  logic [2:0]    queueCount;
`ifdef DELIVERY_QUEUE_STATS_EN
  logic [15:0]   deliveredCount, stallCycles;
`endif

  int checks = 0;
  int errors = 0;

  delivery_request_queue #(
    .addrBits (AW),
    .dataBits (DW),
    .depth    (4)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .core0ReqValid        (core0ReqValid),
    .core0ReqReady        (core0ReqReady),
    .core0TargetProcess   (core0TargetProcess),
    .core0Message         (core0Message),
    .core0NeedsJump       (core0NeedsJump),
    .core0JumpDestination (core0JumpDestination),
    .core1ReqValid        (core1ReqValid),
    .core1ReqReady        (core1ReqReady),
    .core1TargetProcess   (core1TargetProcess),
    .core1Message         (core1Message),
    .core1NeedsJump       (core1NeedsJump),
    .core1JumpDestination (core1JumpDestination),
    .deliveryStart        (deliveryStart),
    .deliveryFinished     (deliveryFinished),
    .targetProcess        (targetProcess),
    .message              (message),
    .needsJump            (needsJump),
    .jumpDestination      (jumpDestination),
    .deliveredToCore0     (deliveredToCore0),
    .deliveredToCore1     (deliveredToCore1),
    .core0Notify          (core0Notify),
    .core1Notify          (core1Notify),
    .queueCount           (queueCount)
`ifdef DELIVERY_QUEUE_STATS_EN
    ,
    .deliveredCount       (deliveredCount),
    .stallCycles          (stallCycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic v, input int tgt, input int msg, input logic nj, input int jd);
    core0ReqValid        = v;
    core0TargetProcess   = AW'(tgt);
    core0Message         = DW'(msg);
    core0NeedsJump       = nj;
    core0JumpDestination = 9'(jd);
  endtask

  task automatic drive1(input logic v, input int tgt, input int msg, input logic nj, input int jd);
    core1ReqValid        = v;
    core1TargetProcess   = AW'(tgt);
    core1Message         = DW'(msg);
    core1NeedsJump       = nj;
    core1JumpDestination = 9'(jd);
  endtask

  int exp_tgt [4] = '{10, 12, 13, 14};
  int exp_msg [4] = '{110, 112, 113, 114};

  initial begin
    reset            = 1'b0;
    deliveryFinished = 1'b0;
    deliveredToCore0 = 1'b0;
    deliveredToCore1 = 1'b0;
    drive0(1'b0, 0, 0, 1'b0, 0);
    drive1(1'b0, 0, 0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_start", deliveryStart, 1'b0);
    chk("rst_count", queueCount, 3'd0);
    chk("rst_notify0", core0Notify, 1'b0);
    chk("rst_notify1", core1Notify, 1'b0);
    chk("rst_target", targetProcess, '0);
`ifdef DELIVERY_QUEUE_STATS_EN
    chk("rst_delivered", deliveredCount, 16'd0);
    chk("rst_stall", stallCycles, 16'd0);
`endif
    reset = 1'b1;
    tick();

    // Single request from core 0
    drive0(1'b1, 3, 42, 1'b0, 0);
    #1;
    chk("t1_ready0", core0ReqReady, 1'b1);
    tick();
    drive0(1'b0, 0, 0, 1'b0, 0);
    #1;
    chk("t1_count", queueCount, 3'd1);
    chk("t1_start_pre", deliveryStart, 1'b0);
    tick();
    chk("t1_start", deliveryStart, 1'b1);
    chk("t1_target", targetProcess, 8'd3);
    chk("t1_message", message, 32'd42);
    chk("t1_needsjump", needsJump, 1'b0);
    tick();
    chk("t1_start_held", deliveryStart, 1'b1);
    chk("t1_target_held", targetProcess, 8'd3);
    deliveryFinished = 1'b1;
    deliveredToCore1 = 1'b1;
    tick();
    deliveryFinished = 1'b0;
    deliveredToCore1 = 1'b0;
    #1;
    chk("t1_start_fall", deliveryStart, 1'b0);
    chk("t1_notify1", core1Notify, 1'b1);
    chk("t1_notify0", core0Notify, 1'b0);
    chk("t1_count_end", queueCount, 3'd0);
    tick();
    chk("t1_notify1_clear", core1Notify, 1'b0);

    // deliveryFinished while idle must be ignored
    deliveryFinished = 1'b1;
    deliveredToCore0 = 1'b1;
    tick();
    deliveryFinished = 1'b0;
    deliveredToCore0 = 1'b0;
    #1;
    chk("idle_fin_notify0", core0Notify, 1'b0);
    chk("idle_fin_start", deliveryStart, 1'b0);

    // Simultaneous requests, priority on core 0
    drive0(1'b1, 5, 100, 1'b1, 'h1AB);
    drive1(1'b1, 6, 200, 1'b0, 0);
    #1;
    chk("t2_ready0", core0ReqReady, 1'b1);
    chk("t2_ready1", core1ReqReady, 1'b1);
    tick();
    drive0(1'b0, 0, 0, 1'b0, 0);
    drive1(1'b0, 0, 0, 1'b0, 0);
    #1;
    chk("t2_count", queueCount, 3'd2);
    tick();
    chk("t2_start", deliveryStart, 1'b1);
    chk("t2_target_first", targetProcess, 8'd5);
    chk("t2_message_first", message, 32'd100);
    chk("t2_needsjump", needsJump, 1'b1);
    chk("t2_jumpdest", jumpDestination, 9'h1AB);
    deliveryFinished = 1'b1;
    deliveredToCore0 = 1'b1;
    tick();
    deliveryFinished = 1'b0;
    deliveredToCore0 = 1'b0;
    #1;
    chk("t2_notify0", core0Notify, 1'b1);
    chk("t2_count_after_pop", queueCount, 3'd1);
    tick();
    chk("t2_gap_start", deliveryStart, 1'b0);
    chk("t2_notify0_clear", core0Notify, 1'b0);
    tick();
    chk("t2_start2", deliveryStart, 1'b1);
    chk("t2_target_second", targetProcess, 8'd6);
    chk("t2_message_second", message, 32'd200);
    deliveryFinished = 1'b1;
    tick();
    deliveryFinished = 1'b0;
    #1;
    chk("t2_count_end", queueCount, 3'd0);
    tick();

    // Fill the queue; priority is now core 1, so its entry goes first
    drive0(1'b1, 10, 110, 1'b0, 0);
    drive1(1'b1, 11, 111, 1'b0, 0);
    #1;
    chk("p3_ready0_a", core0ReqReady, 1'b1);
    chk("p3_ready1_a", core1ReqReady, 1'b1);
    tick();
    drive0(1'b1, 12, 112, 1'b0, 0);
    drive1(1'b1, 13, 113, 1'b0, 0);
    #1;
    chk("p3_count_a", queueCount, 3'd2);
    chk("p3_ready0_b", core0ReqReady, 1'b1);
    chk("p3_ready1_b", core1ReqReady, 1'b1);
    tick();
    drive0(1'b0, 0, 0, 1'b0, 0);
    drive1(1'b1, 14, 114, 1'b0, 0);
    #1;
    chk("p3_count_full", queueCount, 3'd4);
    chk("p3_start", deliveryStart, 1'b1);
    chk("p3_head_prio_core1", targetProcess, 8'd11);
    chk("p3_ready0_full", core0ReqReady, 1'b0);
    chk("p3_ready1_full", core1ReqReady, 1'b0);
    repeat (5) tick();
    chk("p3_ready1_stalled", core1ReqReady, 1'b0);
`ifdef DELIVERY_QUEUE_STATS_EN
    chk("p3_stall5", stallCycles, 16'd5);
`endif
    deliveryFinished = 1'b1;
    #1;
    chk("p3_ready1_fin_cycle", core1ReqReady, 1'b0);
    tick();
    deliveryFinished = 1'b0;
    #1;
    chk("p3_count_pop", queueCount, 3'd3);
    chk("p3_ready1_rise", core1ReqReady, 1'b1);

    // free = 1 with both valid: only core 1 (priority) is granted
    drive0(1'b1, 16, 116, 1'b0, 0);
    #1;
    chk("p3_free1_ready0", core0ReqReady, 1'b0);
    chk("p3_free1_ready1", core1ReqReady, 1'b1);
    tick();
    drive0(1'b0, 0, 0, 1'b0, 0);
    drive1(1'b0, 0, 0, 1'b0, 0);
    #1;
    chk("p3_count_depth", queueCount, 3'd4);
    chk("p3_idle_low", deliveryStart, 1'b0);
    tick();

    // Back-to-back deliveries, finished two cycles after each start
    for (int k = 0; k < 4; k++) begin
      chk("bb_start_rise", deliveryStart, 1'b1);
      chk("bb_target", targetProcess, 8'(exp_tgt[k]));
      chk("bb_message", message, 32'(exp_msg[k]));
      tick();
      chk("bb_start_hold", deliveryStart, 1'b1);
      deliveryFinished = 1'b1;
      tick();
      deliveryFinished = 1'b0;
      #1;
      chk("bb_release_low", deliveryStart, 1'b0);
      tick();
      chk("bb_idle_low", deliveryStart, 1'b0);
      tick();
    end
    chk("drain_start", deliveryStart, 1'b0);
    chk("drain_count", queueCount, 3'd0);
`ifdef DELIVERY_QUEUE_STATS_EN
    chk("drain_delivered", deliveredCount, 16'd8);
    chk("drain_stall", stallCycles, 16'd7);
`endif

    // Asynchronous reset in the middle of a delivery with 2 entries queued
    drive0(1'b1, 20, 120, 1'b0, 0);
    drive1(1'b1, 21, 121, 1'b0, 0);
    #1;
    tick();
    drive0(1'b0, 0, 0, 1'b0, 0);
    drive1(1'b0, 0, 0, 1'b0, 0);
    #1;
    tick();
    chk("rr_start", deliveryStart, 1'b1);
    chk("rr_target", targetProcess, 8'd20);
    chk("rr_count", queueCount, 3'd2);
    #3;
    reset = 1'b0;
    #1;
    chk("rr_async_start", deliveryStart, 1'b0);
    chk("rr_count_clear", queueCount, 3'd0);
    chk("rr_target_clear", targetProcess, 8'd0);
    deliveryFinished = 1'b1;
    deliveredToCore0 = 1'b1;
    tick();
    chk("rr_notify0", core0Notify, 1'b0);
    chk("rr_notify1", core1Notify, 1'b0);
`ifdef DELIVERY_QUEUE_STATS_EN
    chk("rr_delivered_clear", deliveredCount, 16'd0);
`endif
    reset            = 1'b1;
    deliveryFinished = 1'b0;
    deliveredToCore0 = 1'b0;

    // Fresh request after reset release
    drive1(1'b1, 7, 77, 1'b1, 'h055);
    #1;
    chk("fr_ready1", core1ReqReady, 1'b1);
    tick();
    drive1(1'b0, 0, 0, 1'b0, 0);
    #1;
    tick();
    chk("fr_start", deliveryStart, 1'b1);
    chk("fr_target", targetProcess, 8'd7);
    chk("fr_message", message, 32'd77);
    chk("fr_jumpdest", jumpDestination, 9'h055);
    deliveryFinished = 1'b1;
    deliveredToCore0 = 1'b1;
    tick();
    deliveryFinished = 1'b0;
    deliveredToCore0 = 1'b0;
    #1;
    chk("fr_notify0", core0Notify, 1'b1);
    chk("fr_count", queueCount, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
